// File: rtl/rpn_stack_ctrl_if.sv
// Token, stack and result signals between the RPN controller and its neighbours.
// master = controller side; slave = parser/stack/transmit side.
interface rpn_stack_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             tok_valid;
   logic             tok_ready;
   logic [1:0]       tok_kind;
   logic [1:0]       tok_op;
   logic [WIDTH-1:0] tok_val;

   logic             stk_wen;
   logic [WIDTH-1:0] stk_din;
   logic [1:0]       stk_pop_cnt;
   logic [WIDTH-1:0] stk_first;
   logic [WIDTH-1:0] stk_second;

   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             res_ready;

   modport master (
      input  tok_valid, tok_kind, tok_op, tok_val, stk_first, stk_second, res_ready,
      output tok_ready, stk_wen, stk_din, stk_pop_cnt, res_valid, res_data
   );

   modport slave (
      output tok_valid, tok_kind, tok_op, tok_val, stk_first, stk_second, res_ready,
      input  tok_ready, stk_wen, stk_din, stk_pop_cnt, res_valid, res_data
   );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// RPN execution controller: one token -> one stack update cycle, 1 cycle after acceptance.
// Accepts at most one token per 2 cycles; PRINT results held in OUT until res_ready.
module rpn_stack_ctrl #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int DEPTH_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   rpn_stack_ctrl_if.master   bus,
   output logic               err,
   output logic [DEPTH_W-1:0] depth
);
   typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

   localparam logic [1:0] K_NUM   = 2'd0;
   localparam logic [1:0] K_OP    = 2'd1;
   localparam logic [1:0] K_PRINT = 2'd2;
   localparam logic [1:0] K_DROP  = 2'd3;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DUP = 2'd3;

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
   localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] TWO       = DEPTH_W'(2);

   state_t             state_q, state_d;
   logic [1:0]         kind_q, op_q;
   logic [WIDTH-1:0]   val_q;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [WIDTH-1:0]   res_q;
   logic               res_ld;

   logic               wen, tok_rdy, res_vld, exec_err;
   logic [1:0]         pop;
   logic [WIDTH-1:0]   din;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         kind_q  <= '0;
         op_q    <= '0;
         val_q   <= '0;
         depth_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         if (state_q == IDLE && bus.tok_valid) begin
            kind_q <= bus.tok_kind;
            op_q   <= bus.tok_op;
            val_q  <= bus.tok_val;
         end
         if (res_ld) begin
            res_q <= bus.stk_first;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      wen      = 1'b0;
      pop      = 2'd0;
      din      = '0;
      exec_err = 1'b0;
      res_ld   = 1'b0;
      tok_rdy  = 1'b0;
      res_vld  = 1'b0;

      case (state_q)
         IDLE: begin
            tok_rdy = 1'b1;
            if (bus.tok_valid) state_d = EXEC;
         end
         EXEC: begin
            state_d = IDLE;
            case (kind_q)
               K_NUM: begin
                  if (depth_q == DEPTH_MAX) exec_err = 1'b1;
                  else begin
                     wen     = 1'b1;
                     din     = val_q;
                     depth_d = depth_q + ONE;
                  end
               end
               K_OP: begin
                  if (op_q == OP_DUP) begin
                     if (depth_q == '0 || depth_q == DEPTH_MAX) exec_err = 1'b1;
                     else begin
                        wen     = 1'b1;
                        din     = bus.stk_first;
                        depth_d = depth_q + ONE;
                     end
                  end else if (depth_q < TWO) begin
                     exec_err = 1'b1;
                  end else begin
                     wen     = 1'b1;
                     pop     = 2'd2;
                     depth_d = depth_q - ONE;
                     case (op_q)
                        OP_ADD:  din = bus.stk_second + bus.stk_first;
                        OP_SUB:  din = bus.stk_second - bus.stk_first;
                        OP_MUL:  din = WIDTH'(bus.stk_second * bus.stk_first);
                        default: din = '0;
                     endcase
                  end
               end
               K_PRINT: begin
                  if (depth_q == '0) exec_err = 1'b1;
                  else begin
                     res_ld  = 1'b1;
                     state_d = OUT;
                  end
               end
               default: begin
                  if (depth_q == '0) exec_err = 1'b1;
                  else begin
                     pop     = 2'd1;
                     depth_d = depth_q - ONE;
                  end
               end
            endcase
         end
         OUT: begin
            res_vld = 1'b1;
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset cycle must never leak a stack write, result or error pulse.
      if (rst) begin
         tok_rdy  = 1'b0;
         wen      = 1'b0;
         pop      = 2'd0;
         din      = '0;
         exec_err = 1'b0;
         res_vld  = 1'b0;
      end
   end

   assign bus.tok_ready   = tok_rdy;
   assign bus.stk_wen     = wen;
   assign bus.stk_din     = din;
   assign bus.stk_pop_cnt = pop;
   assign bus.res_valid   = res_vld;
   assign bus.res_data    = res_q;
   assign err             = exec_err;
   assign depth           = depth_q;
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed-vector bench with a behavioural stack and queue-based scoreboard.
module tb_rpn_stack_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       err;
   logic [4:0] depth;

   rpn_stack_ctrl_if #(.WIDTH(16)) bus ();

   rpn_stack_ctrl #(.WIDTH(16), .DEPTH(16), .DEPTH_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.master),
      .err   (err),
      .depth (depth)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [1:0]  pop;
      logic [15:0] din;
      logic        er;
      logic [4:0]  dep;
   } exp_t;

   exp_t        exec_q[$];
   logic [15:0] res_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   // Behavioural stack driven by the controller's write port.
   logic [15:0] mem[0:31];
   int          sp;

   always @(posedge clk) begin
      int nsp;
      if (rst) begin
         sp <= 0;
      end else begin
         nsp = sp - int'(bus.stk_pop_cnt);
         if (bus.stk_wen) mem[nsp] <= bus.stk_din;
         sp <= nsp + (bus.stk_wen ? 1 : 0);
      end
   end

   assign bus.stk_first  = (sp > 0) ? mem[sp-1] : 16'd0;
   assign bus.stk_second = (sp > 1) ? mem[sp-2] : 16'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: compares every stack update / error pulse and every result handshake.
   logic       chk_pend = 1'b0;
   logic [4:0] pend_dep;

   always @(negedge clk) begin
      exp_t e;
      logic [15:0] r;
      if (chk_pend) begin
         check("depth_after_exec", 32'(depth), 32'(pend_dep));
         chk_pend = 1'b0;
      end
      if (!rst && (bus.stk_wen || bus.stk_pop_cnt != 2'd0 || err)) begin
         if (exec_q.size() == 0) begin
            check("unexpected_exec", 32'(1), 32'(0));
         end else begin
            e = exec_q.pop_front();
            check("stk_wen", 32'(bus.stk_wen), 32'(e.wen));
            check("stk_pop_cnt", 32'(bus.stk_pop_cnt), 32'(e.pop));
            check("err", 32'(err), 32'(e.er));
            if (e.wen) check("stk_din", 32'(bus.stk_din), 32'(e.din));
            pend_dep = e.dep;
            chk_pend = 1'b1;
         end
      end
      if (!rst && bus.res_valid && bus.res_ready) begin
         if (res_q.size() == 0) begin
            check("unexpected_result", 32'(1), 32'(0));
         end else begin
            r = res_q.pop_front();
            check("res_data", 32'(bus.res_data), 32'(r));
         end
      end
   end

   task automatic issue(input logic [1:0] k, input logic [1:0] op, input logic [15:0] v);
      logic got = 1'b0;
      @(negedge clk);
      bus.tok_kind  = k;
      bus.tok_op    = op;
      bus.tok_val   = v;
      bus.tok_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         if (bus.tok_ready) begin
            @(posedge clk);
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      #1 bus.tok_valid = 1'b0;
      if (!got) check("tok_handshake_timeout", 32'(0), 32'(1));
   endtask

   task automatic tok(input logic [1:0] k, input logic [1:0] op, input logic [15:0] v,
                      input logic wen, input logic [1:0] pop, input logic [15:0] din,
                      input logic er, input logic [4:0] dep);
      exp_t e;
      e.wen = wen; e.pop = pop; e.din = din; e.er = er; e.dep = dep;
      exec_q.push_back(e);
      issue(k, op, v);
   endtask

   task automatic print_ok(input logic [15:0] v);
      res_q.push_back(v);
      issue(2'd2, 2'd0, 16'd0);
   endtask

   task automatic wait_res_valid();
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
      end
      if (!seen) check("res_valid_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.tok_valid = 1'b0;
      bus.tok_kind  = 2'd0;
      bus.tok_op    = 2'd0;
      bus.tok_val   = 16'd0;
      bus.res_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("tok_ready_in_rst", 32'(bus.tok_ready), 32'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_tok_ready", 32'(bus.tok_ready), 32'(1));
      check("rst_stk_wen", 32'(bus.stk_wen), 32'(0));
      check("rst_pop_cnt", 32'(bus.stk_pop_cnt), 32'(0));
      check("rst_stk_din", 32'(bus.stk_din), 32'(0));
      check("rst_res_valid", 32'(bus.res_valid), 32'(0));
      check("rst_res_data", 32'(bus.res_data), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_depth", 32'(depth), 32'(0));

      // 3 + 4, print 7
      tok(0, 0, 16'd3, 1, 0, 16'd3, 0, 5'd1);
      tok(0, 0, 16'd4, 1, 0, 16'd4, 0, 5'd2);
      tok(1, 0, 16'd0, 1, 2, 16'd7, 0, 5'd1);
      print_ok(16'd7);
      tok(3, 0, 16'd0, 0, 1, 16'd0, 0, 5'd0);

      // subtraction incl. unsigned wrap
      tok(0, 0, 16'd10, 1, 0, 16'd10, 0, 5'd1);
      tok(0, 0, 16'd3,  1, 0, 16'd3,  0, 5'd2);
      tok(1, 1, 16'd0,  1, 2, 16'd7,  0, 5'd1);
      tok(0, 0, 16'd0,  1, 0, 16'd0,  0, 5'd2);
      tok(1, 1, 16'd0,  1, 2, 16'd7,  0, 5'd1);
      tok(3, 0, 16'd0,  0, 1, 16'd0,  0, 5'd0);
      tok(0, 0, 16'd0,  1, 0, 16'd0,  0, 5'd1);
      tok(0, 0, 16'd1,  1, 0, 16'd1,  0, 5'd2);
      tok(1, 1, 16'd0,  1, 2, 16'hFFFF, 0, 5'd1);
      tok(3, 0, 16'd0,  0, 1, 16'd0,  0, 5'd0);

      // multiply modulo 2^16, DUP, DROP
      tok(0, 0, 16'd300, 1, 0, 16'd300,   0, 5'd1);
      tok(0, 0, 16'd300, 1, 0, 16'd300,   0, 5'd2);
      tok(1, 2, 16'd0,   1, 2, 16'd24464, 0, 5'd1);
      tok(1, 3, 16'd0,   1, 0, 16'd24464, 0, 5'd2);
      tok(3, 0, 16'd0,   0, 1, 16'd0,     0, 5'd1);
      tok(3, 0, 16'd0,   0, 1, 16'd0,     0, 5'd0);

      // underflow at depth 0
      tok(1, 0, 16'd0, 0, 0, 16'd0, 1, 5'd0);
      tok(2, 0, 16'd0, 0, 0, 16'd0, 1, 5'd0);
      tok(1, 3, 16'd0, 0, 0, 16'd0, 1, 5'd0);
      tok(3, 0, 16'd0, 0, 0, 16'd0, 1, 5'd0);

      // fill to capacity, then overflow
      for (int i = 0; i < 16; i++)
         tok(0, 0, 16'(i + 1), 1, 0, 16'(i + 1), 0, 5'(i + 1));
      tok(0, 0, 16'd99, 0, 0, 16'd0, 1, 5'd16);
      tok(1, 3, 16'd0,  0, 0, 16'd0, 1, 5'd16);
      tok(1, 0, 16'd0,  1, 2, 16'd31, 0, 5'd15);

      // backpressure on the result port
      @(negedge clk);
      bus.res_ready = 1'b0;
      print_ok(16'd31);
      wait_res_valid();
      for (int i = 0; i < 3; i++) begin
         check("bp_res_valid", 32'(bus.res_valid), 32'(1));
         check("bp_res_data", 32'(bus.res_data), 32'(31));
         check("bp_tok_ready", 32'(bus.tok_ready), 32'(0));
         @(negedge clk);
      end
      @(posedge clk); #1 bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_hs_tok_ready", 32'(bus.tok_ready), 32'(1));
      check("post_hs_res_valid", 32'(bus.res_valid), 32'(0));
      check("post_hs_depth", 32'(depth), 32'(15));

      // reset while holding a result in OUT
      bus.res_ready = 1'b0;
      issue(2'd2, 2'd0, 16'd0);
      wait_res_valid();
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_res_valid", 32'(bus.res_valid), 32'(0));
      check("rst_out_depth", 32'(depth), 32'(0));
      check("rst_out_tok_ready", 32'(bus.tok_ready), 32'(1));
      bus.res_ready = 1'b1;

      // reset during EXEC of a NUM
      tok(0, 0, 16'd5, 1, 0, 16'd5, 0, 5'd1);
      issue(2'd0, 2'd0, 16'd77);
      rst = 1'b1;
      @(negedge clk);
      check("rst_exec_stk_wen", 32'(bus.stk_wen), 32'(0));
      check("rst_exec_err", 32'(err), 32'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_exec_depth", 32'(depth), 32'(0));
      check("rst_exec_tok_ready", 32'(bus.tok_ready), 32'(1));

      repeat (5) @(negedge clk);
      check("exec_q_drained", 32'(exec_q.size()), 32'(0));
      check("res_q_drained", 32'(res_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
